// File: rtl/fusion_pkg.sv
// Shared types and helpers for the fusion MAC pipeline.
package fusion_pkg;

    // Legal runtime operand width codes.
    localparam logic [3:0] W1 = 4'd1;
    localparam logic [3:0] W2 = 4'd2;
    localparam logic [3:0] W4 = 4'd4;
    localparam logic [3:0] W8 = 4'd8;

    // Packet state: IDLE means the next accepted beat opens a packet.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Per-packet configuration, widths already legalized.
    typedef struct packed {
        logic [7:0] in_width;
        logic [7:0] weight_width;
        logic       s_in;
        logic       s_weight;
    } cfg_t;

    // Map an illegal width code (0, non-power-of-two, above max_w) to max_w.
    function automatic logic [7:0] width_legalize(input logic [3:0] w, input int unsigned max_w);
        logic legal;
        legal = (w == W1) || (w == W2) || (w == W4) || (w == W8);
        if (legal && (32'(w) <= max_w)) begin
            return {4'd0, w};
        end
        return 8'(max_w);
    endfunction

    // Unsigned 2x2 bit-brick product.
    function automatic logic [3:0] brick_mul(input logic [1:0] a, input logic [1:0] b);
        return {2'b00, a} * {2'b00, b};
    endfunction

endpackage

// File: rtl/bitbrick_array.sv
// Combinational bit-brick multiplier: (MAX_W/2)^2 unsigned 2x2 bricks plus
// sign correction for the extended top bit of each operand.
module bitbrick_array
    import fusion_pkg::*;
#(
    parameter int MAX_W = 8
) (
    input  logic [MAX_W:0]               a_i,
    input  logic [MAX_W:0]               b_i,
    output logic signed [2*MAX_W+1:0]    prod_o
);

    localparam int PW = 2*MAX_W + 2;
    localparam int NB = MAX_W / 2;

    // Shift-add the brick grid, then fold in the -2^MAX_W weight of each top bit.
    always_comb begin
        // NOTE: blocking assignments here build the running sum step by step; combinational logic only.
        prod_o = '0;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < NB; j++) begin
                prod_o = prod_o + (PW'(brick_mul(a_i[2*i +: 2], b_i[2*j +: 2])) << (2*(i+j)));
            end
        end
        if (a_i[MAX_W]) prod_o = prod_o - (PW'(b_i[MAX_W-1:0]) << MAX_W);
        if (b_i[MAX_W]) prod_o = prod_o - (PW'(a_i[MAX_W-1:0]) << MAX_W);
        if (a_i[MAX_W] && b_i[MAX_W]) prod_o = prod_o + (PW'(1) << (2*MAX_W));
    end

endmodule

// File: rtl/fusion_mac_pipe.sv
// Three-stage pipelined multi-precision MAC: one operand pair per cycle,
// one registered sum per in_last-delimited packet.
module fusion_mac_pipe
    import fusion_pkg::*;
#(
    parameter int MAX_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAX_W-1:0] in_data,
    input  logic [MAX_W-1:0] weight,
    input  logic             in_last,
    input  logic [3:0]       in_width,
    input  logic [3:0]       weight_width,
    input  logic             s_in,
    input  logic             s_weight,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int PW = 2*MAX_W + 2;

    logic stall, accept;
    state_t state_q, state_d;
    cfg_t cfg_q, cfg_d, in_cfg, beat_cfg;

    logic             s1_valid_q, s1_last_q;
    logic [MAX_W-1:0] s1_a_q, s1_b_q;
    cfg_t             s1_cfg_q;
    logic [MAX_W:0]   a_ext, b_ext;
    logic             a_fill, b_fill, a_msb, b_msb;
    logic signed [PW-1:0] prod;

    logic                 s2_valid_q, s2_last_q, s2_signed_q;
    logic signed [PW-1:0] s2_prod_q;

    logic [ACC_W-1:0] acc_q, prod_ext, sum;
    logic [ACC_W:0]   sum_wide;
    logic             ovf_q, beat_ovf, out_valid_q, out_ovf_q;
    logic [ACC_W-1:0] out_data_q;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    assign in_cfg.in_width     = width_legalize(in_width, MAX_W);
    assign in_cfg.weight_width = width_legalize(weight_width, MAX_W);
    assign in_cfg.s_in         = s_in;
    assign in_cfg.s_weight     = s_weight;

    // Packet FSM: the first beat of a packet supplies the config, later beats reuse it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d  = state_q;
        cfg_d    = cfg_q;
        beat_cfg = (state_q == IDLE) ? in_cfg : cfg_q;
        if (accept) begin
            cfg_d   = beat_cfg;
            state_d = in_last ? IDLE : ACCUM;
        end
    end

    // Packet state and held config.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
        end
    end

    // S1: capture operands, packet config and last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cfg_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_last;
            s1_a_q     <= in_data;
            s1_b_q     <= weight;
            s1_cfg_q   <= beat_cfg;
        end
    end

    // Zero/sign-extend the low width bits of each operand to MAX_W+1 bits.
    always_comb begin
        a_msb = 1'b0;
        b_msb = 1'b0;
        for (int k = 0; k < MAX_W; k++) begin
            if (k == int'(s1_cfg_q.in_width) - 1)     a_msb = s1_a_q[k];
            if (k == int'(s1_cfg_q.weight_width) - 1) b_msb = s1_b_q[k];
        end
        a_fill = s1_cfg_q.s_in & a_msb;
        b_fill = s1_cfg_q.s_weight & b_msb;
        for (int k = 0; k < MAX_W; k++) begin
            a_ext[k] = (k < int'(s1_cfg_q.in_width))     ? s1_a_q[k] : a_fill;
            b_ext[k] = (k < int'(s1_cfg_q.weight_width)) ? s1_b_q[k] : b_fill;
        end
        a_ext[MAX_W] = a_fill;
        b_ext[MAX_W] = b_fill;
    end

    bitbrick_array #(.MAX_W(MAX_W)) u_bricks (
        .a_i    (a_ext),
        .b_i    (b_ext),
        .prod_o (prod)
    );

    // S2: register the exact product and the packet's accumulate mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_signed_q <= 1'b0;
            s2_prod_q   <= '0;
        end else if (!stall) begin
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            s2_signed_q <= s1_cfg_q.s_in | s1_cfg_q.s_weight;
            s2_prod_q   <= prod;
        end
    end

    // Wrapping add with signed-overflow or carry-out detection.
    always_comb begin
        prod_ext = ACC_W'(s2_prod_q);
        sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
        sum      = sum_wide[ACC_W-1:0];
        beat_ovf = s2_signed_q
                 ? ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                 : sum_wide[ACC_W];
    end

    // S3: accumulate; on the last beat load the output register and clear for the next packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    out_data_q <= sum;
                    out_ovf_q  <= ovf_q | beat_ovf;
                    acc_q      <= '0;
                    ovf_q      <= 1'b0;
                end else begin
                    acc_q <= sum;
                    ovf_q <= ovf_q | beat_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fusion_mac_pipe.sv
// Self-checking bench for fusion_mac_pipe: directed steps, scoreboard of packet sums.
module tb_fusion_mac_pipe;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, s_in = 1'b0, s_weight = 1'b0;
    logic out_ready = 1'b1, sel16 = 1'b0;
    logic [7:0] in_data = '0, weight = '0;
    logic [3:0] in_width = 4'd8, weight_width = 4'd8;

    logic v_a, v_b;
    logic in_ready_a, out_valid_a, out_ovf_a;
    logic [31:0] out_data_a;
    logic in_ready_b, out_valid_b, out_ovf_b;
    logic [15:0] out_data_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int n_checks = 0, n_pass = 0;
    int cyc = 0, last_pop = -1, gaps = 0, stall_cycles = 0;
    bit sweeping = 1'b0;

    // Packet model state.
    bit     m_open = 1'b0, m_si = 1'b0, m_sw = 1'b0, m_ovf = 1'b0;
    int     m_wi = 8, m_ww = 8;
    longint m_acc = 0;

    assign v_a = in_valid & ~sel16;
    assign v_b = in_valid & sel16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fusion_mac_pipe #(.MAX_W(8), .ACC_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a), .in_ready(in_ready_a),
        .in_data(in_data), .weight(weight), .in_last(in_last),
        .in_width(in_width), .weight_width(weight_width), .s_in(s_in), .s_weight(s_weight),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a)
    );

    fusion_mac_pipe #(.MAX_W(8), .ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(v_b), .in_ready(in_ready_b),
        .in_data(in_data), .weight(weight), .in_last(in_last),
        .in_width(in_width), .weight_width(weight_width), .s_in(s_in), .s_weight(s_weight),
        .out_valid(out_valid_b), .out_ready(1'b1), .out_data(out_data_b), .out_ovf(out_ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int legal_w(input logic [3:0] w);
        return (w == 4'd1 || w == 4'd2 || w == 4'd4 || w == 4'd8) ? int'(w) : 8;
    endfunction

    function automatic longint operand(input logic [7:0] d, input int w, input bit sgn);
        longint v;
        v = longint'(d) & ((longint'(1) << w) - 1);
        if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return v;
    endfunction

    // Reference accumulate of one accepted beat; pushes the packet sum on the last beat.
    task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input bit last,
                              input logic [3:0] wi, input logic [3:0] ww, input bit si, input bit sw);
        longint p, s, modv, acc_s;
        exp_t e;
        if (!m_open) begin
            m_wi = legal_w(wi); m_ww = legal_w(ww); m_si = si; m_sw = sw;
        end
        p = operand(a, m_wi, m_si) * operand(b, m_ww, m_sw);
        modv = longint'(1) << (sel16 ? 16 : 32);
        if (m_si | m_sw) begin
            acc_s = (m_acc >= modv / 2) ? m_acc - modv : m_acc;
            s = acc_s + p;
            if (s < -(modv / 2) || s >= modv / 2) m_ovf = 1'b1;
        end else begin
            s = m_acc + p;
            if (s >= modv) m_ovf = 1'b1;
        end
        m_acc = ((s % modv) + modv) % modv;
        if (last) begin
            e.data = 32'(m_acc);
            e.ovf  = m_ovf;
            if (sel16) q_b.push_back(e); else q_a.push_back(e);
            m_acc = 0;
            m_ovf = 1'b0;
        end
        m_open = !last;
    endtask

    // Drive one beat from the negedge and hold it until the DUT accepts it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last,
                        input logic [3:0] wi, input logic [3:0] ww, input bit si, input bit sw);
        int guard;
        @(negedge clk);
        in_valid = 1'b1; in_data = a; weight = b; in_last = last;
        in_width = wi; weight_width = ww; s_in = si; s_weight = sw;
        guard = 0;
        while (!(sel16 ? in_ready_b : in_ready_a) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        stall_cycles += guard;
        if (guard >= 64) begin
            check("send_ready_timeout", guard, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_beat(a, b, last, wi, ww, si, sw);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Change out_ready away from both edges so the negedge monitor sees a settled value.
    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 out_ready = v;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_a_empty", q_a.size(), 0);
        check("drain_b_empty", q_b.size(), 0);
    endtask

    // Output monitor: every handshake pops and compares one expected sum.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid_a && out_ready) begin
                check("a_result_expected", q_a.size() != 0, 1'b1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    check("a_out_data", out_data_a, e.data);
                    check("a_out_ovf", out_ovf_a, e.ovf);
                end
                if (sweeping && last_pop >= 0 && cyc != last_pop + 1) gaps++;
                last_pop = cyc;
            end
            if (out_valid_b) begin
                check("b_result_expected", q_b.size() != 0, 1'b1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    check("b_out_data", {16'd0, out_data_b}, e.data);
                    check("b_out_ovf", out_ovf_b, e.ovf);
                end
            end
        end
    end

    initial begin
        int g;
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid_a, 1'b0);
        check("rst_out_data", out_data_a, 32'd0);
        check("rst_out_ovf", out_ovf_a, 1'b0);
        check("rst_in_ready", in_ready_a, 1'b1);
        rst_n = 1'b1;

        // Signed 4x4 single beat: -5 * 6, result exactly three cycles after acceptance.
        send(8'h0B, 8'h06, 1'b1, 4'd4, 4'd4, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_t1_valid", out_valid_a, 1'b0);
        @(negedge clk);
        check("lat_t2_valid", out_valid_a, 1'b0);
        @(negedge clk);
        check("lat_t3_valid", out_valid_a, 1'b1);
        check("lat_t3_data", out_data_a, 32'hFFFF_FFE2);
        check("lat_t3_ovf", out_ovf_a, 1'b0);

        // 2b accumulation with a mid-packet config change, then back-to-back packets.
        send(8'd3, 8'd3, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0);
        send(8'hF2, 8'd1, 1'b0, 4'd8, 4'd2, 1'b1, 1'b1);
        send(8'd1, 8'd3, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
        send(8'h0F, 8'd3, 1'b1, 4'd4, 4'd4, 1'b1, 1'b0);
        send(8'd1, 8'd5, 1'b1, 4'd1, 4'd4, 1'b1, 1'b0);
        send(8'h80, 8'h02, 1'b1, 4'd3, 4'd0, 1'b1, 1'b1);
        send(8'h7F, 8'hFF, 1'b0, 4'd8, 4'd8, 1'b0, 1'b1);
        send(8'hFF, 8'h81, 1'b1, 4'd8, 4'd8, 1'b0, 1'b1);
        idle();
        drain();

        // Unsigned 8x8 sweep, one beat per packet at full rate.
        sweeping = 1'b1; last_pop = -1; gaps = 0; stall_cycles = 0;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                send(8'(i), 8'(j), 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
            end
        end
        idle();
        drain();
        sweeping = 1'b0;
        check("sweep_output_gaps", gaps, 0);
        check("sweep_input_stalls", stall_cycles, 0);

        // Backpressure: five stalled cycles with a result pending, then release.
        set_ready(1'b0);
        fork
            begin
                send(8'd7, 8'd9, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
                send(8'd2, 8'd3, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0);
                send(8'd4, 8'd5, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
                send(8'd11, 8'd13, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
                send(8'd17, 8'd19, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
                idle();
            end
            begin
                int gw;
                gw = 0;
                while (!out_valid_a && gw < 20) begin
                    @(negedge clk);
                    gw++;
                end
                if (gw >= 20) check("bp_valid_timeout", gw, 0);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready_a, 1'b0);
                    check("bp_out_valid", out_valid_a, 1'b1);
                    check("bp_out_data_stable", out_data_a, q_a[0].data);
                end
                set_ready(1'b1);
            end
        join
        drain();

        // 16-bit accumulator: unsigned carry-out, then signed overflow.
        idle();
        sel16 = 1'b1;
        send(8'd255, 8'd255, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0);
        send(8'd255, 8'd255, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
        send(8'd1, 8'd1, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b0, 4'd8, 4'd8, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b1, 4'd8, 4'd8, 1'b1, 1'b1);
        idle();
        drain();
        sel16 = 1'b0;

        // Reset mid-packet with a result held at the output.
        set_ready(1'b0);
        send(8'd7, 8'd7, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
        send(8'd1, 8'd2, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0);
        send(8'd3, 8'd4, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0);
        idle();
        g = 0;
        while (!out_valid_a && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("prerst_out_valid", out_valid_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_a, 1'b0);
        check("midrst_out_data", out_data_a, 32'd0);
        check("midrst_out_ovf", out_ovf_a, 1'b0);
        check("midrst_in_ready", in_ready_a, 1'b1);
        q_a.delete();
        m_open = 1'b0; m_acc = 0; m_ovf = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd5, 8'd5, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fusion_mac_pipe.md
# fusion_mac_pipe

Pipelined, parametrised successor to the combinational `fusion_unit` multiplier. It accepts one operand pair per cycle over a valid/ready stream. Each operand pair is multiplied at runtime-selectable bit widths (1/2/4/8 up to `MAX_W`) with independent sign control, built from 2x2 bit-brick partial products. Products are accumulated across a packet delimited by `in_last`, and one registered sum per packet is emitted downstream to the PE-array psum path.

## Interface
- `MAX_W`, 8: maximum operand width; power of two, ≥2.
- `ACC_W`, 32: accumulator and output width; ≥ 2*`MAX_W`.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `in_data` input `MAX_W`: input activation; low `in_width` bits used.
- `weight` input `MAX_W`: weight; low `weight_width` bits used.
- `in_last` input 1: final beat of packet.
- `in_width` input 4: activation width, legal 1/2/4/8 (≤`MAX_W`).
- `weight_width` input 4: weight width, same legal set.
- `s_in` input 1: activation is two's complement.
- `s_weight` input 1: weight is two's complement.
- `out_valid` output 1: packet sum valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output `ACC_W`: packet sum.
- `out_ovf` output 1: sticky overflow for this packet.

## Operation
- Config (`in_width`, `weight_width`, `s_in`, `s_weight`) is sampled on the first accepted beat of a packet and held to its `in_last`. Changes mid-packet are ignored.
- An illegal width (0, non-power-of-two, >`MAX_W`) is treated as `MAX_W`.
- Operand extension: the low w bits are zero- or sign-extended to `MAX_W`+1 bits. 1-bit signed value 1 = −1.
- The product is formed as the sum of (`MAX_W`/2)² 2x2 brick products, each shifted by 2*(i+j), with the sign handled on the extended top bit. The result is exact for all width/sign combinations.
- Accumulation is signed if (`s_in|s_weight`) for the packet, else unsigned, and wraps modulo 2^`ACC_W`.
- `out_ovf` is set if any add in the packet had a signed overflow (signed mode) or a carry-out (unsigned mode).
- On the `in_last` beat, the final sum is written to the output register and the accumulator clears for the next packet. A single-beat packet is legal.
- States: IDLE (no packet open), ACCUM (packet open). IDLE→ACCUM on accepted non-last beat; ACCUM→IDLE on accepted last beat; a last beat accepted in IDLE stays in IDLE.
- Reset clears all valids, the accumulator, the sticky overflow, and the state (→IDLE). Outputs after reset: `out_valid`=0, `out_data`=0, `out_ovf`=0, `in_ready`=1. A packet in flight at reset is discarded.

## Timing
- Pipeline stages:
  - S1: register operands, config and last.
  - S2: register the shifted brick-product sum.
  - S3: accumulate; on last, load the output register.
- Latency: the accepted last beat at cycle t gives `out_valid`=1 at t+3 when unstalled.
- Stall: `stall = out_valid && !out_ready`, and `in_ready = !stall`. When stalled, every stage holds and S3 does not accumulate.
- Throughput is 1 beat/cycle, with back-to-back packets without bubbles.
- `out_valid` and `out_data` stay stable until `out_valid && out_ready`. The output may be consumed and reloaded in the same cycle.
- `in_ready` is combinational from `out_ready`. There is no combinational path from `in_valid` to any output.

## Structure
- Shared package `fusion_pkg`:
  - width-code constants (W1/W2/W4/W8);
  - the `width_legalize` function;
  - the config struct {`in_width`, `weight_width`, `s_in`, `s_weight`}.
- Sub-module `bitbrick_array`: combinational (`MAX_W`/2)² brick grid plus shift-add, taking the extended operands and returning a signed 2*`MAX_W`+2-bit product. It sits between S1 and S2.

## Test plan
- Signed 4x4: `s_in`=`s_weight`=1, `in_data`=8'h0B (−5), `weight`=8'h06, single-beat → `out_data`=32'hFFFF_FFE2 (−30), `out_ovf`=0, 3 cycles after acceptance.
- Unsigned 8x8 sweep: all 65536 pairs, one beat per packet, `out_ready`=1 → each `out_data`=i*j, one result per cycle after fill.
- 2b accumulation: beats (3,3),(2,1),(1,3 last) → `out_data`=14. The next packet, started the cycle after, is unaffected.
- Backpressure: hold `out_ready`=0 for 5 cycles with a result pending → `in_ready`=0, `out_data` stable. Release → one handshake, then the stream resumes with no lost or duplicated beats.
- Overflow: `ACC_W`=16, unsigned 8x8, beats (255,255),(255,255 last) → `out_data`=16'hFC02, `out_ovf`=1. The next packet (1,1 last) → 1, `out_ovf`=0.
- Reset mid-packet: assert `rst_n`=0 after 2 beats of a 4-beat packet → outputs cleared immediately. A fresh packet (5,5 last) → 25.
